rx_word_aligner: RTL and testbench

//  Downstream of the deserializer. Takes its unaligned 10-bit words (c_parallel_out

---
 rtl/rx_word_aligner.sv | 155 +++++++++++++++
 tb/tb_rx_word_aligner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_word_aligner.sv
// rx_word_aligner: finds the K28.5 comma in the unaligned deserializer words,
// locks a bit offset through a LOS/CHECK/SYNC state machine and emits
// word-aligned 10-bit codes with a one-clock latency.
module rx_word_aligner #(
  parameter int SYNC_COMMAS    = 3,
  parameter int MISALIGN_LIMIT = 4,
  parameter int TIMEOUT_WORDS  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] c_parallel_in,
  input  logic       c_data_valid_in,
  output logic [9:0] d_aligned_out,
  output logic       d_data_valid,
  output logic       d_comma_det,
  output logic       sync_ok,
  output logic [3:0] align_offset,
  output logic [7:0] los_cnt
);

  localparam logic [9:0] K28_5_RDM = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
  localparam int CW = $clog2(SYNC_COMMAS + 1);
  localparam int MW = $clog2(MISALIGN_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_WORDS + 1);

  typedef enum logic [1:0] {ST_LOS, ST_CHECK, ST_SYNC} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [MW-1:0]   mis_reg, mis_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic [3:0]      offset_next;
  logic [7:0]      los_next;
  logic [9:0]      prev_word;
  logic [19:0]     window;
  logic [9:0]      cand [10];
  logic [9:0]      match;
  logic            any_comma;
  logic [3:0]      first_k;
  logic            locked_hit;
  logic            lose;

  // Previous valid word supplies the upper half of the 20-bit search window.
  assign window = {prev_word, c_parallel_in};

  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_cand
      assign cand[gi]  = window[19-gi -: 10];
      assign match[gi] = (cand[gi] == K28_5_RDM) || (cand[gi] == K28_5_RDP);
    end
  endgenerate

  assign any_comma  = |match;
  assign locked_hit = match[align_offset];
  assign sync_ok    = (state_reg == ST_SYNC);

  // Priority encoder: scanning downward leaves the lowest matching offset.
  always_comb begin
    first_k = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (match[k]) first_k = 4'(k);
    end
  end

  // Next-state and counter logic; only valid words advance the machine.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    mis_next    = mis_reg;
    tmo_next    = tmo_reg;
    offset_next = align_offset;
    los_next    = los_cnt;
    lose        = 1'b0;
    if (c_data_valid_in) begin
      case (state_reg)
        ST_LOS: begin
          if (any_comma) begin
            offset_next = first_k;
            cnt_next    = CW'(1);
            state_next  = (SYNC_COMMAS == 1) ? ST_SYNC : ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (locked_hit) begin
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == CW'(SYNC_COMMAS - 1)) state_next = ST_SYNC;
          end else if (any_comma) begin
            offset_next = first_k;
            cnt_next    = CW'(1);
          end
        end
        ST_SYNC: begin
          if (locked_hit) begin
            mis_next = '0;
            tmo_next = '0;
          end else begin
            tmo_next = tmo_reg + TW'(1);
            if (tmo_reg == TW'(TIMEOUT_WORDS - 1)) lose = 1'b1;
            if (any_comma) begin
              mis_next = mis_reg + MW'(1);
              if (mis_reg == MW'(MISALIGN_LIMIT - 1)) lose = 1'b1;
            end
          end
          if (lose) begin
            state_next = ST_LOS;
            cnt_next   = '0;
            mis_next   = '0;
            tmo_next   = '0;
            if (los_cnt != 8'hFF) los_next = los_cnt + 8'd1;
          end
        end
        default: state_next = ST_LOS;
      endcase
    end
  end

  // State, counters, history word and locked offset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_LOS;
      cnt_reg      <= '0;
      mis_reg      <= '0;
      tmo_reg      <= '0;
      align_offset <= 4'd0;
      los_cnt      <= 8'd0;
      prev_word    <= 10'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      mis_reg      <= mis_next;
      tmo_reg      <= tmo_next;
      align_offset <= offset_next;
      los_cnt      <= los_next;
      if (c_data_valid_in) prev_word <= c_parallel_in;
    end
  end

  // Output word uses the offset in force before this word's state update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_aligned_out <= 10'd0;
      d_data_valid  <= 1'b0;
      d_comma_det   <= 1'b0;
    end else if (c_data_valid_in && (state_reg != ST_LOS)) begin
      d_aligned_out <= cand[align_offset];
      d_data_valid  <= 1'b1;
      d_comma_det   <= locked_hit;
    end else begin
      d_data_valid  <= 1'b0;
      d_comma_det   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_word_aligner.sv
// Bench for rx_word_aligner: directed bit streams at several offsets, with a
// scoreboard queue filled at stimulus time and drained by an output monitor.
module tb_rx_word_aligner;

  localparam logic [9:0] K  = 10'b0011111010;
  localparam logic [9:0] KP = 10'b1100000101;
  localparam logic [9:0] A  = 10'b1010101010;
  localparam logic [9:0] B  = 10'b0101010101;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] c_parallel_in;
  logic       c_data_valid_in;
  logic [9:0] d_aligned_out;
  logic       d_data_valid;
  logic       d_comma_det;
  logic       sync_ok;
  logic [3:0] align_offset;
  logic [7:0] los_cnt;

  typedef struct {
    logic [9:0] word;
    logic       comma;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  logic [9:0] i_prev;
  logic [9:0] o_prev;

  rx_word_aligner dut (
    .clk             (clk),
    .rst             (rst),
    .c_parallel_in   (c_parallel_in),
    .c_data_valid_in (c_data_valid_in),
    .d_aligned_out   (d_aligned_out),
    .d_data_valid    (d_data_valid),
    .d_comma_det     (d_comma_det),
    .sync_ok         (sync_ok),
    .align_offset    (align_offset),
    .los_cnt         (los_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: every presented output word is matched against the queue head.
  always @(negedge clk) begin
    if (d_data_valid === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected actual=%b required=none", d_aligned_out);
      end else begin
        mon_e = q.pop_front();
        if (d_aligned_out !== mon_e.word || d_comma_det !== mon_e.comma) begin
          bad++;
          $display("FAIL out_word actual=%b/%b required=%b/%b",
                   d_aligned_out, d_comma_det, mon_e.word, mon_e.comma);
        end else begin
          $display("out word=%b comma=%b", d_aligned_out, d_comma_det);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send_raw(input logic [9:0] i, input bit emit, input logic [9:0] ew, input logic ec);
    exp_t e;
    c_parallel_in   = i;
    c_data_valid_in = 1'b1;
    if (emit) begin
      e.word  = ew;
      e.comma = ec;
      q.push_back(e);
    end
    i_prev = i;
    @(posedge clk);
    #1;
  endtask

  // Serialises original word o_word into the stream delayed by 'shift' bits.
  // If the DUT reads at the true shift, the emitted word is the previous original word.
  task automatic send_o(input logic [9:0] o_word, input int shift, input bit emit, input int off);
    logic [19:0] pair;
    logic [19:0] win;
    logic [9:0]  i;
    logic [9:0]  ew;
    logic        ec;
    pair = {o_prev, o_word} >> shift;
    i    = pair[9:0];
    if (off == shift) begin
      ew = o_prev;
      ec = (o_prev == K);
    end else begin
      win = {i_prev, i} >> (10 - off);
      ew  = win[9:0];
      ec  = (ew == K) || (ew == KP);
    end
    o_prev = o_word;
    send_raw(i, emit, ew, ec);
  endtask

  task automatic idle();
    c_data_valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    rst             = 1'b1;
    c_data_valid_in = 1'b0;
    c_parallel_in   = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    i_prev = 10'd0;
    o_prev = A;
  endtask

  initial begin
    logic [9:0] t2 [10];
    logic [9:0] ow;
    t2 = '{A, K, A, K, A, K, B, A, B, A};

    // 1: reset values
    rst             = 1'b1;
    c_data_valid_in = 1'b0;
    c_parallel_in   = 10'd0;
    i_prev          = 10'd0;
    o_prev          = A;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(d_aligned_out), 32'd0);
    check("rst_valid", 32'(d_data_valid), 32'd0);
    check("rst_comma", 32'(d_comma_det), 32'd0);
    check("rst_sync", 32'(sync_ok), 32'd0);
    check("rst_offset", 32'(align_offset), 32'd0);
    check("rst_los", 32'(los_cnt), 32'd0);
    rst = 1'b0;

    // 2: commas at offset 0
    for (int n = 0; n < 10; n++) begin
      send_o(t2[n], 0, n >= 3, 0);
      if (n == 5) check("t2_sync_pre", 32'(sync_ok), 32'd0);
      if (n == 6) begin
        check("t2_sync", 32'(sync_ok), 32'd1);
        check("t2_offset", 32'(align_offset), 32'd0);
      end
    end

    // 3 + 4: offset 3 lock, then stream moves to offset 8
    do_reset();
    for (int n = 0; n < 44; n++) begin
      ow = (n % 4 == 0) ? K : ((n % 4 == 2) ? B : A);
      if (n < 16) send_o(ow, 3, n >= 2, 3);
      else        send_o(ow, 8, (n <= 29) || (n >= 34), (n <= 29) ? 3 : 8);
      if (n == 8) check("t3_sync_pre", 32'(sync_ok), 32'd0);
      if (n == 9) begin
        check("t3_sync", 32'(sync_ok), 32'd1);
        check("t3_offset", 32'(align_offset), 32'd3);
      end
      if (n == 28) begin
        check("t4_sync_hold", 32'(sync_ok), 32'd1);
        check("t4_los_pre", 32'(los_cnt), 32'd0);
      end
      if (n == 29) begin
        check("t4_los_sync", 32'(sync_ok), 32'd0);
        check("t4_los_cnt", 32'(los_cnt), 32'd1);
        check("t4_offset_hold", 32'(align_offset), 32'd3);
      end
      if (n == 33) check("t4_check_offset", 32'(align_offset), 32'd8);
      if (n == 40) check("t4_relock_pre", 32'(sync_ok), 32'd0);
      if (n == 41) begin
        check("t4_relock", 32'(sync_ok), 32'd1);
        check("t4_relock_offset", 32'(align_offset), 32'd8);
      end
    end

    // 5: timeout after 1024 valid words without the locked comma
    do_reset();
    for (int n = 0; n < 4; n++) send_o(K, 0, n >= 2, 0);
    check("t5_sync", 32'(sync_ok), 32'd1);
    for (int j = 0; j < 1025; j++) begin
      send_o((j % 2 == 0) ? A : B, 0, 1'b1, 0);
      if (j == 500) begin
        repeat (5) idle();
        check("t5_idle_sync", 32'(sync_ok), 32'd1);
      end
      if (j == 1023) check("t5_sync_pre", 32'(sync_ok), 32'd1);
      if (j == 1024) begin
        check("t5_timeout", 32'(sync_ok), 32'd0);
        check("t5_los_cnt", 32'(los_cnt), 32'd1);
      end
    end
    send_o(A, 0, 1'b0, 0);

    // 6: reset in CHECK after two commas, then a fresh count
    do_reset();
    send_o(A, 5, 1'b0, 5);
    send_o(K, 5, 1'b0, 5);
    send_o(K, 5, 1'b0, 5);
    send_o(A, 5, 1'b1, 5);
    check("t6_check_offset", 32'(align_offset), 32'd5);
    do_reset();
    check("t6_rst_offset", 32'(align_offset), 32'd0);
    check("t6_rst_sync", 32'(sync_ok), 32'd0);
    check("t6_rst_valid", 32'(d_data_valid), 32'd0);
    check("t6_rst_los", 32'(los_cnt), 32'd0);
    send_o(K, 0, 1'b0, 0);
    send_o(A, 0, 1'b0, 0);
    check("t6_first_sync", 32'(sync_ok), 32'd0);
    send_o(K, 0, 1'b1, 0);
    send_o(A, 0, 1'b1, 0);
    check("t6_second_sync", 32'(sync_ok), 32'd0);
    send_o(K, 0, 1'b1, 0);
    send_o(A, 0, 1'b1, 0);
    check("t6_third_sync", 32'(sync_ok), 32'd1);

    c_data_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("queue_final", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
